// File: rtl/psoa_logit.sv
// psoa_logit: inverse sigmoid by bit-serial bisection
// against an external fixed-latency psoa_sigmoid.
module psoa_logit #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 10,
  parameter int ITER      = 13,
  parameter int SIG_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic             sat,
  output logic [WIDTH-1:0] sig_x,
  input  logic [WIDTH-1:0] sig_fx
);

  localparam int BW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int CW = $clog2(SIG_LAT + 1);

  localparam logic [WIDTH-1:0] ONE  =
    WIDTH'(1) << FRAC_BITS;
  localparam logic [WIDTH-1:0] HALF = ONE >> 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROBE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic             neg;
  logic [ITER-1:0]  acc;
  logic [BW-1:0]    b;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] y_clip;
  logic [ITER-1:0]  trial;
  logic [WIDTH-1:0] mag;

  assign y_clip = (y > ONE) ? ONE : y;
  assign trial  = acc | (ITER'(1) << b);
  assign mag    = WIDTH'(acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tgt   <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      b     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sat   <= 1'b0;
      x_out <= '0;
      sig_x <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          busy <= start;
          if (start) begin
            neg   <= (y_clip < HALF);
            tgt   <= (y_clip >= HALF) ? y_clip
                                      : ONE - y_clip;
            acc   <= '0;
            b     <= BW'(ITER - 1);
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (tgt >= ONE) begin
            acc   <= '1;
            sat   <= 1'b1;
            state <= S_FIN;
          end else begin
            sat   <= 1'b0;
            state <= S_PROBE;
          end
        end
        S_PROBE: begin
          sig_x <= WIDTH'(trial);
          cnt   <= CW'(SIG_LAT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          // counter hits zero on this edge: sig_fx is valid
          if (cnt == CW'(1)) begin
            if (sig_fx <= tgt)
              acc <= trial;
            if (b == '0) begin
              state <= S_FIN;
            end else begin
              b     <= b - 1'b1;
              state <= S_PROBE;
            end
          end
        end
        S_FIN: begin
          x_out <= neg ? -mag : mag;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psoa_logit.sv
// tb_psoa_logit: random and directed checks of psoa_logit
// against a table-scan reference of the logit search.
module tb_psoa_logit;

  localparam int LAT_N = 2 + 13 * 2;
  localparam int LAT_S = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic [15:0] x_out;
  logic        sat;
  logic [15:0] sig_x;
  logic [15:0] sig_fx;

  int errors = 0;
  int checks = 0;
  int tab [8192];

  psoa_logit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .sat   (sat),
    .sig_x (sig_x),
    .sig_fx(sig_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sigm(input int x);
    real r;
    r = 1024.0 / (1.0 + $exp(-real'(x) / 1024.0));
    return $rtoi(r + 0.5);
  endfunction

  // sigmoid responder: valid one edge after sig_x moves
  always_comb sig_fx = 16'(sigm(int'(sig_x)));

  task automatic check(input string tag,
                       input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic void model(input int yv,
                                output logic [15:0] xo,
                                output logic so);
    int yc, tgt, m;
    bit ng;
    yc = (yv > 1024) ? 1024 : yv;
    ng = (yc < 512);
    tgt = ng ? 1024 - yc : yc;
    so = 1'b0;
    m = 0;
    if (tgt >= 1024) begin
      m = 8191;
      so = 1'b1;
    end else begin
      for (int i = 0; i < 8192; i++)
        if (tab[i] <= tgt) m = i;
    end
    xo = ng ? 16'(-m) : 16'(m);
  endfunction

  task automatic run(input logic [15:0] yv,
                     output logic [15:0] xo,
                     output logic so,
                     output int lat,
                     output int bad);
    @(negedge clk);
    start = 1'b1;
    y = yv;
    @(posedge clk);
    #1;
    start = 1'b0;
    y = 16'($urandom);
    lat = 0;
    bad = 0;
    while (!done && lat < 200) begin
      if (!busy) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!busy) bad++;
    xo = x_out;
    so = sat;
    check("done_seen", int'(done), 1);
  endtask

  task automatic req(input string tag,
                     input logic [15:0] yv);
    logic [15:0] xo, xe;
    logic so, se;
    int lat, bad;
    model(int'(yv), xe, se);
    run(yv, xo, so, lat, bad);
    check({tag, "_x"}, int'(xo), int'(xe));
    check({tag, "_sat"}, int'(so), int'(se));
    check({tag, "_lat"}, lat, se ? LAT_S : LAT_N);
    check({tag, "_busy"}, bad, 0);
  endtask

  initial begin
    logic [15:0] xo, xe;
    logic so, se;
    int lat, bad, m, n;
    int d [3];

    for (int i = 0; i < 8192; i++) tab[i] = sigm(i);

    rst_n = 1'b0;
    start = 1'b0;
    y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_sigx", int'(sig_x), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'd512, xo, so, lat, bad);
    check("ctr_range", int'(xo <= 16'd2), 1);
    check("ctr_sat", int'(so), 0);
    check("ctr_lat", lat, LAT_N);
    check("ctr_busy", bad, 0);

    req("pos902", 16'd902);
    m = int'(x_out);
    check("pos_near", int'(m >= 2032 && m <= 2064), 1);
    check("pos_brk",
          int'(tab[m] <= 902 && tab[m + 1] > 902), 1);

    req("neg120", 16'd120);
    m = -int'($signed(x_out));
    check("neg_near", int'(m >= 2051 && m <= 2083), 1);
    check("neg_brk",
          int'(tab[m] <= 904 && tab[m + 1] > 904), 1);

    req("sat1024", 16'd1024);
    check("sat1024_v", int'(x_out), 8191);
    req("sat0", 16'd0);
    check("sat0_v", int'(x_out), 16'hE001);
    req("sat2000", 16'd2000);
    req("y511", 16'd511);
    req("y1023", 16'd1023);
    req("y1", 16'd1);

    for (int k = 0; k < 20; k++)
      req("rnd", 16'($urandom_range(0, 1200)));

    // a second start mid-search must not disturb the first
    model(700, xe, se);
    @(negedge clk);
    start = 1'b1;
    y = 16'd700;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == 10) begin
        start = 1'b1;
        y = 16'd100;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("ign_lat", lat, LAT_N);
    check("ign_x", int'(x_out), int'(xe));
    @(posedge clk);
    #1;

    // start held high: one result per LAT_N + 1 edges
    model(902, xe, se);
    @(negedge clk);
    start = 1'b1;
    y = 16'd902;
    n = 0;
    m = 0;
    while (n < 3 && m < 200) begin
      @(posedge clk);
      #1;
      m++;
      if (done) begin
        d[n] = m;
        check("held_x", int'(x_out), int'(xe));
        n++;
      end
    end
    check("held_cnt", n, 3);
    check("held_gap1", d[1] - d[0], LAT_N + 1);
    check("held_gap2", d[2] - d[1], LAT_N + 1);
    start = 1'b0;
    m = 0;
    while (busy && m < 100) begin
      @(posedge clk);
      #1;
      m++;
    end
    check("held_idle", int'(busy), 0);

    // asynchronous reset mid-search
    @(negedge clk);
    start = 1'b1;
    y = 16'd300;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("amid_busy", int'(busy), 0);
    check("amid_done", int'(done), 0);
    check("amid_x", int'(x_out), 0);
    check("amid_sigx", int'(sig_x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_idle", int'(busy), 0);
    req("post902", 16'd902);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
